// File: rtl/mbisr_pkg.sv
// Shared types and sizing helpers for the MBIST repair controller.
package mbisr_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  // Width of a counter able to hold 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of an index into n entries (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mbisr_repair_cam.sv
// Repair table: NUM_SPARES x {valid, addr} with a capture match port,
// a mission match port, lowest-free allocation and bulk clear.
module mbisr_repair_cam
  import mbisr_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_SPARES = 4,
  localparam int IDX_W = idx_w(NUM_SPARES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  alloc,
  input  logic [ADDR_WIDTH-1:0] alloc_addr,
  input  logic [ADDR_WIDTH-1:0] cap_addr,
  output logic                  cap_hit,
  input  logic [ADDR_WIDTH-1:0] mis_addr,
  output logic                  mis_hit,
  output logic [IDX_W-1:0]      mis_idx,
  output logic                  full
);

  logic                  valid_q [NUM_SPARES];
  logic                  valid_d [NUM_SPARES];
  logic [ADDR_WIDTH-1:0] addr_q  [NUM_SPARES];
  logic [ADDR_WIDTH-1:0] addr_d  [NUM_SPARES];
  logic [NUM_SPARES-1:0] valid_vec;
  logic [NUM_SPARES-1:0] cap_match;
  logic [NUM_SPARES-1:0] mis_match;
  logic [IDX_W-1:0]      free_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPARES; gi++) begin : g_entry
      assign valid_vec[gi] = valid_q[gi];
      assign cap_match[gi] = valid_q[gi] && (addr_q[gi] == cap_addr);
      assign mis_match[gi] = valid_q[gi] && (addr_q[gi] == mis_addr);

      // Entry update: clear wins, otherwise only the lowest free slot takes an allocation.
      always_comb begin
        valid_d[gi] = valid_q[gi];
        addr_d[gi]  = addr_q[gi];
        if (clr) begin
          valid_d[gi] = 1'b0;
        end else if (alloc && !full && (free_idx == IDX_W'(gi))) begin
          valid_d[gi] = 1'b1;
          addr_d[gi]  = alloc_addr;
        end
      end

      // Entry storage.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
          addr_q[gi]  <= '0;
        end else begin
          valid_q[gi] <= valid_d[gi];
          addr_q[gi]  <= addr_d[gi];
        end
      end
    end
  endgenerate

  assign full    = &valid_vec;
  assign cap_hit = |cap_match;
  assign mis_hit = |mis_match;

  // Lowest free index and matching index; entries are unique so any match is the match.
  always_comb begin
    free_idx = '0;
    mis_idx  = '0;
    for (int i = NUM_SPARES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) free_idx = IDX_W'(i);
      if (mis_match[i])  mis_idx  = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mbisr_repair_ctrl.sv
// Test-and-repair sequencer: launches MBIST, logs unique failing addresses,
// owns the memory port and redirects repaired addresses to spare words.
module mbisr_repair_ctrl
  import mbisr_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SPARES = 4,
  localparam int CNT_W = cnt_w(NUM_SPARES),
  localparam int IDX_W = idx_w(NUM_SPARES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bist_req,
  input  logic                  sys_we,
  input  logic [ADDR_WIDTH-1:0] sys_addr,
  input  logic [DATA_WIDTH-1:0] sys_wdata,
  output logic [DATA_WIDTH-1:0] sys_rdata,
  output logic                  sys_ready,
  output logic                  mb_start,
  input  logic                  mb_done,
  input  logic                  mb_fail_valid,
  input  logic [ADDR_WIDTH-1:0] mb_fail_addr,
  input  logic                  mb_we,
  input  logic [ADDR_WIDTH-1:0] mb_addr,
  input  logic [DATA_WIDTH-1:0] mb_wdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  repair_done,
  output logic                  repair_ok,
  output logic [CNT_W-1:0]      fail_count,
  output logic                  overflow
);

  state_t           state_q, state_d;
  logic             mb_start_q, busy_q, repair_done_q, sys_ready_q;
  logic             repair_ok_q, repair_ok_d, overflow_q, overflow_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic             cam_clr, cam_alloc, cap_hit, mis_hit, full;
  logic [IDX_W-1:0] mis_idx;

  logic [DATA_WIDTH-1:0] spare_q [NUM_SPARES];
  logic [DATA_WIDTH-1:0] spare_d [NUM_SPARES];

  mbisr_repair_cam #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SPARES (NUM_SPARES)
  ) u_cam (
    .clk        (clk),
    .rst        (rst),
    .clr        (cam_clr),
    .alloc      (cam_alloc),
    .alloc_addr (mb_fail_addr),
    .cap_addr   (mb_fail_addr),
    .cap_hit    (cap_hit),
    .mis_addr   (sys_addr),
    .mis_hit    (mis_hit),
    .mis_idx    (mis_idx),
    .full       (full)
  );

  // Sequencer next state, fail capture and repair status.
  always_comb begin
    state_d      = state_q;
    repair_ok_d  = repair_ok_q;
    overflow_d   = overflow_q;
    fail_count_d = fail_count_q;
    cam_clr      = 1'b0;
    cam_alloc    = 1'b0;
    case (state_q)
      ST_IDLE:   if (bist_req) state_d = ST_CLEAR;
      ST_CLEAR: begin
        cam_clr      = 1'b1;
        fail_count_d = '0;
        overflow_d   = 1'b0;
        repair_ok_d  = 1'b0;
        state_d      = ST_LAUNCH;
      end
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        // A fail in the mb_done cycle is still captured before REPORT reads overflow.
        if (mb_fail_valid && !cap_hit) begin
          if (!full) begin
            cam_alloc    = 1'b1;
            fail_count_d = fail_count_q + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (mb_done) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        repair_ok_d = ~overflow_q;
        state_d     = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; status outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mb_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      repair_done_q <= 1'b0;
      sys_ready_q   <= 1'b1;
      repair_ok_q   <= 1'b0;
      overflow_q    <= 1'b0;
      fail_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      mb_start_q    <= (state_d == ST_LAUNCH);
      busy_q        <= (state_d != ST_IDLE);
      repair_done_q <= (state_d == ST_REPORT);
      sys_ready_q   <= (state_d == ST_IDLE);
      repair_ok_q   <= repair_ok_d;
      overflow_q    <= overflow_d;
      fail_count_q  <= fail_count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPARES; gi++) begin : g_spare
      // Spare word takes functional writes aimed at its repaired address.
      always_comb begin
        spare_d[gi] = spare_q[gi];
        if ((state_q == ST_IDLE) && sys_we && mis_hit && (mis_idx == IDX_W'(gi)))
          spare_d[gi] = sys_wdata;
      end

      // Spare word storage.
      always_ff @(posedge clk) begin
        if (rst) spare_q[gi] <= '0;
        else     spare_q[gi] <= spare_d[gi];
      end
    end
  endgenerate

  // Memory port ownership and mission-mode remap.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = sys_addr;
    mem_wdata = sys_wdata;
    sys_rdata = mem_rdata;
    case (state_q)
      ST_IDLE: begin
        mem_we = sys_we && !mis_hit;
        if (mis_hit) sys_rdata = spare_q[mis_idx];
      end
      ST_LAUNCH, ST_RUN: begin
        mem_we    = mb_we;
        mem_addr  = mb_addr;
        mem_wdata = mb_wdata;
      end
      default: mem_we = 1'b0;
    endcase
  end

  assign mb_start    = mb_start_q;
  assign busy        = busy_q;
  assign repair_done = repair_done_q;
  assign sys_ready   = sys_ready_q;
  assign repair_ok   = repair_ok_q;
  assign overflow    = overflow_q;
  assign fail_count  = fail_count_q;

endmodule
